vlt_sq_accum: RTL

VLT_SQ_ACCUM -- requirements
Module: vlt_sq_accum

---
 rtl/vlt_sq_accum.sv | 138 +++++++++++++
 1 files changed

// File: rtl/vlt_sq_accum.sv
// Store-retire vulnerability accumulator.
// Records are queued in a 4-entry FIFO. The head is weighted by two opcode-selected
// shifts, staged for one cycle, and then summed into saturating accumulators.
// A RUN/DRAIN/DONE FSM implements the flush handshake.
module vlt_sq_accum (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [8:0]  opcode_i,
  input  logic        important_i,
  input  logic [9:0]  start_ts_i,
  input  logic [9:0]  end_ts_i,
  input  logic        hold_i,
  input  logic        clear_i,
  input  logic        flush_i,
  output logic [31:0] accum_o,
  output logic [15:0] count_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef struct packed {
    logic [8:0] opcode;
    logic       important;
    logic [9:0] start_ts;
    logic [9:0] end_ts;
  } rec_t;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t      state, state_nxt;
  rec_t        fifo_q [4];
  logic [1:0]  rd_ptr, wr_ptr;
  logic [2:0]  fcnt;
  logic        push, pop;
  logic        stg_vld;
  logic [17:0] stg_contrib;
  rec_t        head;
  logic [9:0]  dur;
  logic [2:0]  s1, s2;
  logic        sv;
  logic [17:0] contrib;
  logic [32:0] sum;

  assign head       = fifo_q[rd_ptr];
  assign in_ready_o = (fcnt != 3'd4) && (state == RUN);
  assign push       = in_valid_i && in_ready_o;
  assign pop        = (fcnt != 3'd0) && !hold_i;
  assign busy_o     = (fcnt != 3'd0) || stg_vld;
  assign sum        = {1'b0, accum_o} + {15'd0, stg_contrib};

  // Weight the FIFO head: modular duration, shifted by the opcode-selected pair.
  always_comb begin
    dur = head.end_ts - head.start_ts;
    sv  = 1'b0;
    s1  = 3'd6;
    s2  = 3'd3;
    case (head.opcode)
      9'd15, 9'd8, 9'd7, 9'd16: begin
        sv = 1'b1;
        if (head.important) s2 = 3'd5;
      end
      9'd6: begin
        sv = 1'b1;
        if (head.important) s2 = 3'd4;
      end
      9'd18, 9'd21, 9'd23, 9'd17, 9'd10: begin
        sv = 1'b1;
        if (head.important) s1 = 3'd7;
      end
      default: sv = 1'b0;
    endcase
    contrib = sv ? (({8'd0, dur} << s1) + ({8'd0, dur} << s2)) : 18'd0;
  end

  // FIFO storage. Contents need no reset because the pointers and count qualify them.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr] <= '{opcode_i, important_i, start_ts_i, end_ts_i};
  end

  // FIFO pointers and count. Push and pop may occur in the same cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fcnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      fcnt <= fcnt + {2'd0, push} - {2'd0, pop};
    end
  end

  // Stage register. It holds exactly one popped contribution for one cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stg_vld     <= 1'b0;
      stg_contrib <= '0;
    end else begin
      stg_vld <= pop;
      if (pop) stg_contrib <= contrib;
    end
  end

  // Saturating accumulators. A clear wins over a coincident staged record and discards it.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      accum_o <= '0;
      count_o <= '0;
    end else if (stg_vld) begin
      accum_o <= sum[32] ? 32'hFFFF_FFFF : sum[31:0];
      if (count_o != 16'hFFFF) count_o <= count_o + 16'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state <= RUN;
    else         state <= state_nxt;
  end

  // Flush sequencing. DRAIN waits for the FIFO and stage to be empty; DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    done_o    = 1'b0;
    case (state)
      RUN:     if (flush_i) state_nxt = DRAIN;
      DRAIN:   if (fcnt == 3'd0 && !stg_vld) state_nxt = DONE;
      DONE: begin
        done_o    = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

endmodule
